rd_pending_tracker: RTL

RD_PENDING_TRACKER -- requirements
Module: rd_pending_tracker

---
 rtl/rd_pending_tracker.sv | 82 ++++++++
 1 files changed

// File: rtl/rd_pending_tracker.sv
// ============================================================================
// rd_pending_tracker: per-register outstanding-write scoreboard (x1..x31)
// Optional macro RD_PENDING_TRACKER_FORWARD_EN: same-cycle writeback bypass on busy
// Revision: 1.0
// ============================================================================
`default_nettype none

module rd_pending_tracker #(
  parameter int CNT_W = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       issue_valid,
  input  logic [4:0] issue_rd,
  output logic       issue_ready,
  input  logic       wb_valid,
  input  logic [4:0] wb_rd,
  input  logic       flush,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  output logic       rs1_busy,
  output logic       rs2_busy,
  output logic       stall,
  output logic [6:0] outstanding,
  output logic       wb_underflow
);

  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

  // Entry 0 is held at zero so x0 reads as never pending.
  logic [CNT_W-1:0] cnt [0:31];

  logic wb_hit;
  logic wb_dec;
  logic issue_fire;
  logic same_rd;
  logic out_inc;
  logic out_dec;

  always_comb begin
    wb_hit      = wb_valid && (wb_rd != 5'd0);
    same_rd     = wb_hit && (wb_rd == issue_rd);
    issue_ready = (cnt[issue_rd] != MAX) || same_rd;
    issue_fire  = issue_valid && issue_ready && (issue_rd != 5'd0);
    wb_dec      = wb_hit && (cnt[wb_rd] != '0);
    out_inc     = issue_fire && !same_rd;
    out_dec     = wb_dec && !(issue_fire && same_rd);
  end

  always_comb begin
    rs1_busy = (rs1 != 5'd0) && (cnt[rs1] != '0);
    rs2_busy = (rs2 != 5'd0) && (cnt[rs2] != '0);
`ifdef RD_PENDING_TRACKER_FORWARD_EN
    // The last pending write to a source retiring this cycle frees it early.
    if (wb_valid && (wb_rd == rs1) && (cnt[rs1] == CNT_W'(1))) rs1_busy = 1'b0;
    if (wb_valid && (wb_rd == rs2) && (cnt[rs2] == CNT_W'(1))) rs2_busy = 1'b0;
`endif
    stall = rs1_busy || rs2_busy;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      for (int i = 0; i < 32; i++) cnt[i] <= '0;
      outstanding  <= 7'd0;
      wb_underflow <= 1'b0;
    end else begin
      cnt[0] <= '0;
      for (int i = 1; i < 32; i++) begin
        // Issue and writeback on the same register cancel each other out.
        if (issue_fire && (issue_rd == 5'(i)) && !(wb_hit && (wb_rd == 5'(i))))
          cnt[i] <= cnt[i] + CNT_W'(1);
        else if (wb_dec && (wb_rd == 5'(i)) && !(issue_fire && (issue_rd == 5'(i))))
          cnt[i] <= cnt[i] - CNT_W'(1);
      end
      outstanding  <= outstanding + 7'(out_inc) - 7'(out_dec);
      wb_underflow <= wb_hit && (cnt[wb_rd] == '0);
    end
  end

endmodule

`default_nettype wire
